// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared FSM encoding and sizing helpers for the FIFO port arbiters
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int C_BEAT_W = 4;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_BURST = 1'b1;

    // Owner index width; never narrower than one bit, even for two producers.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker, searching upward from last+1
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    int                w_idx;
    logic [ID_W-1:0]   w_sel;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(last_owner) + k) % NUM_REQ;
            w_sel = ID_W'(w_idx);
            if (req[w_sel]) begin
                winner = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Burst-based round-robin arbiter sharing one FIFO write port
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din_flat,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [ID_W-1:0]           owner_id,
    output logic                      busy
);

    localparam logic [ID_W-1:0]     C_LAST_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [C_BEAT_W-1:0] C_MAX_BEAT  = C_BEAT_W'(MAX_BURST);

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       last_owner_q, last_owner_d;
    logic [C_BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]       w_winner;
    logic                  w_any_req;
    logic                  w_accept;
    logic [C_BEAT_W-1:0]   w_beat_next;
    logic [DATA_W-1:0]     w_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = din_flat[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (w_winner),
        .any_req    (w_any_req)
    );

    // Reset gates the beat so nothing is written in a cycle being reset.
    assign w_accept    = (state_q == ST_BURST) && req[owner_q] && !fifo_full && !reset;
    assign w_beat_next = beat_cnt_q + C_BEAT_W'(1);

    always_comb begin
        gnt = '0;
        if (w_accept) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign fifo_wr_en = w_accept;
    assign fifo_din   = w_accept ? w_slice[owner_q] : '0;
    assign owner_id   = owner_q;
    assign busy       = (state_q == ST_BURST);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    owner_d    = w_winner;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_accept) begin
                    beat_cnt_d = w_beat_next;
                    if (w_beat_next == C_MAX_BEAT) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (!req[owner_q]) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= C_LAST_INIT;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter (4 x 8-bit)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din_flat;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic [1:0]  owner_id;
    logic        busy;

    logic [7:0]  din_v [4];
    logic [7:0]  exp_q [$];
    int          total;
    int          bad;

    assign din_flat = {din_v[3], din_v[2], din_v[1], din_v[0]};

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .din_flat   (din_flat),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .owner_id   (owner_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle.
    task automatic step(input logic [3:0] r, input logic f, input logic rs,
                        input logic [3:0] eg, input logic eb, input int eo);
        logic [7:0] d;
        req       = r;
        fifo_full = f;
        reset     = rs;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) exp_q.push_back(din_v[i]);
        end
        #4;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("wr_en", 32'(fifo_wr_en), 32'(eg != 4'b0));
        chk("busy", 32'(busy), 32'(eb));
        if (eo >= 0) chk("owner_id", 32'(owner_id), 32'(eo));
        if (fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(fifo_din), 32'hFFFF_FFFF);
            end else begin
                d = exp_q.pop_front();
                chk("fifo_din", 32'(fifo_din), 32'(d));
            end
        end else begin
            chk("fifo_din_idle", 32'(fifo_din), 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        din_v[0]  = 8'h0F;
        din_v[1]  = 8'h5A;
        din_v[2]  = 8'hA5;
        din_v[3]  = 8'h3C;
        reset     = 1'b1;
        req       = 4'hF;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with every producer requesting
        step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 0);
        step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 0);

        // Full contention: owners 0,1,2,3,0, four beats each, one idle between
        for (int b = 0; b < 5; b++) begin
            step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, (b == 0) ? 0 : -1);
            for (int j = 0; j < 4; j++) begin
                step(4'b1111, 1'b0, 1'b0, 4'(1 << (b % 4)), 1'b1, b % 4);
            end
        end
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1);

        // Single producer 2: four writes per five cycles
        step(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, -1);
        for (int j = 0; j < 4; j++) step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2);
        step(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2);
        for (int j = 0; j < 4; j++) step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2);

        // Back-pressure on owner 1 after two beats
        step(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, -1);
        for (int j = 0; j < 2; j++) begin
            step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1);
            din_v[1] = din_v[1] + 8'd1;
        end
        for (int j = 0; j < 3; j++) step(4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1);
        for (int j = 0; j < 2; j++) begin
            step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1);
            din_v[1] = din_v[1] + 8'd1;
        end

        // Early drop by owner 0 after two beats; producer 1 wins next
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, -1);
        step(4'b0111, 1'b0, 1'b0, 4'b0001, 1'b1, 0);
        din_v[0] = 8'hC3;
        step(4'b0111, 1'b0, 1'b0, 4'b0001, 1'b1, 0);
        step(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 0);
        step(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0, 0);
        step(4'b0110, 1'b0, 1'b0, 4'b0010, 1'b1, 1);
        step(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 1);

        // Reset during owner 2's second beat; producer 0 wins afterwards
        step(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, -1);
        step(4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 2);
        step(4'b0101, 1'b0, 1'b1, 4'b0000, 1'b1, 2);
        step(4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, 0);
        step(4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0);

        chk("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
